// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and registered EX forward-select flags.
// Optional: define STALL_CNT_EN to add the perf_stall_cnt output (saturating stall-cycle counter).
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_wr_en,
  input  logic            id_is_load,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_wr_en,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_wr_en,
  output logic            ex_is_load,
  output logic            ex_fwd_a_mem,
  output logic            ex_fwd_a_wb,
  output logic            ex_fwd_b_mem,
  output logic            ex_fwd_b_wb
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [REGW-1:0] r_rd;
  logic            r_wr_en;
  logic            r_is_load;
  logic            r_fwd_a_mem;
  logic            r_fwd_a_wb;
  logic            r_fwd_b_mem;
  logic            r_fwd_b_wb;

  logic            w_ex_valid;
  logic            w_hz;
  logic            w_xfer;
  logic            w_a_mem;
  logic            w_a_wb;
  logic            w_b_mem;
  logic            w_b_wb;

  // A producer matches a source only if it writes a non-zero register with that index.
  function automatic logic fwd_hit(input logic v, input logic we,
                                   input logic [REGW-1:0] rd,
                                   input logic [REGW-1:0] rs);
    return v & we & (rd != '0) & (rd == rs);
  endfunction

  assign w_ex_valid = (r_state == FULL);

  assign w_hz = w_ex_valid & r_is_load & r_wr_en & (r_rd != '0)
              & ((r_rd == id_rs1) | (r_rd == id_rs2));

  assign id_ready = ~w_hz & (~w_ex_valid | ex_ready);
  assign w_xfer   = id_valid & id_ready;

  // The EX occupant moves to MEM on transfer; the MEM occupant moves to WB. MEM wins.
  assign w_a_mem = fwd_hit(w_ex_valid, r_wr_en, r_rd, id_rs1);
  assign w_a_wb  = ~w_a_mem & fwd_hit(1'b1, mem_wr_en, mem_rd, id_rs1);
  assign w_b_mem = fwd_hit(w_ex_valid, r_wr_en, r_rd, id_rs2);
  assign w_b_wb  = ~w_b_mem & fwd_hit(1'b1, mem_wr_en, mem_rd, id_rs2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_wr_en     <= 1'b0;
      r_is_load   <= 1'b0;
      r_fwd_a_mem <= 1'b0;
      r_fwd_a_wb  <= 1'b0;
      r_fwd_b_mem <= 1'b0;
      r_fwd_b_wb  <= 1'b0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_fwd_a_mem <= 1'b0;
      r_fwd_a_wb  <= 1'b0;
      r_fwd_b_mem <= 1'b0;
      r_fwd_b_wb  <= 1'b0;
    end else if (w_xfer) begin
      r_state     <= FULL;
      r_rs1_val   <= id_rs1_val;
      r_rs2_val   <= id_rs2_val;
      r_imm       <= id_imm;
      r_rd        <= id_rd;
      r_wr_en     <= id_wr_en;
      r_is_load   <= id_is_load;
      r_fwd_a_mem <= w_a_mem;
      r_fwd_a_wb  <= w_a_wb;
      r_fwd_b_mem <= w_b_mem;
      r_fwd_b_wb  <= w_b_wb;
    end else if (r_state == FULL && ex_ready) begin
      // Drain or load-use bubble: nothing new enters, the old bundle is consumed.
      r_state <= EMPTY;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (id_valid && !id_ready && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

  assign ex_valid     = w_ex_valid;
  assign ex_rs1_val   = r_rs1_val;
  assign ex_rs2_val   = r_rs2_val;
  assign ex_imm       = r_imm;
  assign ex_rd        = r_rd;
  assign ex_wr_en     = r_wr_en;
  assign ex_is_load   = r_is_load;
  assign ex_fwd_a_mem = r_fwd_a_mem;
  assign ex_fwd_a_wb  = r_fwd_a_wb;
  assign ex_fwd_b_mem = r_fwd_b_mem;
  assign ex_fwd_b_wb  = r_fwd_b_wb;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage, plus hand sequences for backpressure, flush and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm;
  logic        id_wr_en, id_is_load, mem_wr_en, ex_ready, flush;
  logic        ex_valid;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_wr_en, ex_is_load;
  logic        ex_fwd_a_mem, ex_fwd_a_wb, ex_fwd_b_mem, ex_fwd_b_wb;
`ifdef STALL_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .mem_rd(mem_rd), .mem_wr_en(mem_wr_en),
    .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_fwd_a_mem(ex_fwd_a_mem), .ex_fwd_a_wb(ex_fwd_a_wb),
    .ex_fwd_b_mem(ex_fwd_b_mem), .ex_fwd_b_wb(ex_fwd_b_wb)
`ifdef STALL_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic        vld;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1;
    logic        wr, ld;
    logic [4:0]  mrd;
    logic        mwr, rdy, fl;
    logic        e_idr;   // expected id_ready before the edge
    logic        e_vld;   // expected ex_valid after the edge
    logic [3:0]  e_fwd;   // {a_mem, a_wb, b_mem, b_wb} after the edge
    logic        chk;     // row transfers: ex_* must equal this row's inputs
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [31:0] v1, logic wr, logic ld, logic [4:0] mrd, logic mwr,
                              logic rdy, logic fl, logic e_idr, logic e_vld,
                              logic [3:0] e_fwd, logic chk);
    vec_t v;
    v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.v1 = v1; v.wr = wr; v.ld = ld;
    v.mrd = mrd; v.mwr = mwr; v.rdy = rdy; v.fl = fl;
    v.e_idr = e_idr; v.e_vld = e_vld; v.e_fwd = e_fwd; v.chk = chk;
    return v;
  endfunction

  function automatic logic [31:0] v2_of(logic [31:0] v1);
    return v1 ^ 32'hFFFF_0000;
  endfunction

  function automatic logic [31:0] imm_of(logic [31:0] v1);
    return v1 + 32'h100;
  endfunction

  task automatic apply(input vec_t v);
    id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_rs1_val = v.v1; id_rs2_val = v2_of(v.v1); id_imm = imm_of(v.v1);
    id_wr_en = v.wr; id_is_load = v.ld; mem_rd = v.mrd; mem_wr_en = v.mwr;
    ex_ready = v.rdy; flush = v.fl;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] fwd_now();
    return {ex_fwd_a_mem, ex_fwd_a_wb, ex_fwd_b_mem, ex_fwd_b_wb};
  endfunction

  initial begin
    //        vld rs1 rs2 rd  v1          wr ld mrd mwr rdy fl  idr vld fwd      chk
    tbl.push_back(mk(1, 1,  0,  2,  32'h11, 1, 0, 0,  0,  1,  0,  1,  1,  4'b0000, 1)); // first instr
    tbl.push_back(mk(1, 1,  0,  5,  32'h0A, 1, 0, 0,  0,  1,  0,  1,  1,  4'b0000, 1)); // ADD rd=5
    tbl.push_back(mk(1, 5,  6,  8,  32'h0B, 1, 0, 0,  0,  1,  0,  1,  1,  4'b1000, 1)); // SUB rs1=5
    tbl.push_back(mk(1, 0,  0,  3,  32'h0C, 1, 0, 0,  0,  1,  0,  1,  1,  4'b0000, 1)); // rd=3 non-load
    tbl.push_back(mk(1, 3,  3,  9,  32'h0D, 1, 0, 3,  1,  1,  0,  1,  1,  4'b1010, 1)); // MEM beats WB
    tbl.push_back(mk(1, 0,  0,  7,  32'h0E, 1, 1, 0,  0,  1,  0,  1,  1,  4'b0000, 1)); // LW rd=7
    tbl.push_back(mk(1, 0,  7,  10, 32'h0F, 1, 0, 0,  0,  1,  0,  0,  0,  4'b0000, 0)); // load-use bubble
    tbl.push_back(mk(1, 0,  7,  10, 32'h0F, 1, 0, 7,  1,  1,  0,  1,  1,  4'b0001, 1)); // ADD, b_wb
    tbl.push_back(mk(1, 1,  0,  0,  32'h20, 1, 1, 0,  0,  1,  0,  1,  1,  4'b0000, 1)); // LW rd=0
    tbl.push_back(mk(1, 0,  0,  12, 32'h21, 1, 1, 0,  0,  1,  0,  1,  1,  4'b0000, 1)); // rs=0: no stall/fwd
    tbl.push_back(mk(1, 12, 0,  13, 32'h22, 1, 0, 0,  0,  1,  0,  0,  0,  4'b0000, 0)); // rs1 load-use
    tbl.push_back(mk(1, 12, 0,  13, 32'h22, 1, 0, 12, 1,  1,  0,  1,  1,  4'b0100, 1)); // a_wb
    tbl.push_back(mk(0, 0,  0,  0,  32'h00, 0, 0, 0,  0,  1,  0,  1,  0,  4'b0100, 0)); // drain
    tbl.push_back(mk(1, 0,  0,  14, 32'h23, 1, 0, 0,  0,  1,  0,  1,  1,  4'b0000, 1));
    tbl.push_back(mk(1, 0,  14, 15, 32'h24, 0, 0, 0,  0,  1,  0,  1,  1,  4'b0010, 1)); // b_mem
    tbl.push_back(mk(1, 15, 0,  16, 32'h25, 1, 0, 0,  1,  1,  0,  1,  1,  4'b0000, 1)); // wr=0 / idx 0
    tbl.push_back(mk(0, 0,  0,  0,  32'h00, 0, 0, 0,  0,  0,  0,  0,  1,  4'b0000, 0)); // backpressure
    tbl.push_back(mk(1, 16, 0,  17, 32'h26, 1, 0, 16, 1,  1,  0,  1,  1,  4'b1000, 1)); // a_mem over wb

    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset rs1_val", ex_rs1_val, 32'd0);
    check("reset rd", {27'd0, ex_rd}, 32'd0);
    check("reset fwd", {28'd0, fwd_now()}, 32'd0);
    check("reset id_ready", {31'd0, id_ready}, 32'd1);
`ifdef STALL_CNT_EN
    check("reset stall_cnt", perf_stall_cnt, 32'd0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check($sformatf("row%0d id_ready", i), {31'd0, id_ready}, {31'd0, tbl[i].e_idr});
      @(posedge clk);
      #1;
      check($sformatf("row%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, tbl[i].e_vld});
      check($sformatf("row%0d fwd", i), {28'd0, fwd_now()}, {28'd0, tbl[i].e_fwd});
      if (tbl[i].chk) begin
        check($sformatf("row%0d rs1_val", i), ex_rs1_val, tbl[i].v1);
        check($sformatf("row%0d rs2_val", i), ex_rs2_val, v2_of(tbl[i].v1));
        check($sformatf("row%0d imm", i), ex_imm, imm_of(tbl[i].v1));
        check($sformatf("row%0d rd", i), {27'd0, ex_rd}, {27'd0, tbl[i].rd});
        check($sformatf("row%0d wr_ld", i), {30'd0, ex_wr_en, ex_is_load},
              {30'd0, tbl[i].wr, tbl[i].ld});
      end
`ifdef STALL_CNT_EN
      if (i == 6) check("stall_cnt after load-use", perf_stall_cnt, 32'd1);
`endif
    end

    // Backpressure with a forwarded bundle held, then flush while stalled.
    @(negedge clk);
    apply(mk(1, 17, 0, 20, 32'h55, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0));
    @(posedge clk); #1;
    check("bp load valid", {31'd0, ex_valid}, 32'd1);
    check("bp load fwd", {28'd0, fwd_now()}, 32'h8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      apply(mk(1, 0, 0, 21, 32'h66, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0));
      #1;
      check($sformatf("bp%0d id_ready", k), {31'd0, id_ready}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("bp%0d ex_valid", k), {31'd0, ex_valid}, 32'd1);
      check($sformatf("bp%0d rs1_val", k), ex_rs1_val, 32'h55);
      check($sformatf("bp%0d rd", k), {27'd0, ex_rd}, 32'd20);
      check($sformatf("bp%0d fwd", k), {28'd0, fwd_now()}, 32'h8);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush stalled id_ready", {31'd0, id_ready}, 32'd0);
    @(posedge clk); #1;
    check("flush ex_valid", {31'd0, ex_valid}, 32'd0);
    check("flush fwd", {28'd0, fwd_now()}, 32'd0);
    @(negedge clk);
    #1;
    check("flush empty id_ready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1;
    check("flush discards accepted", {31'd0, ex_valid}, 32'd0);
`ifdef STALL_CNT_EN
    check("stall_cnt after bp", perf_stall_cnt, 32'd6);
`endif

    // Reset in the middle of operation, together with flush and a transfer.
    @(negedge clk);
    apply(mk(1, 0, 0, 22, 32'h70, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0));
    @(negedge clk);
    apply(mk(1, 22, 0, 23, 32'h77, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 0));
    @(posedge clk); #1;
    check("pre-rst fwd", {28'd0, fwd_now()}, 32'h8);
    check("pre-rst rs1_val", ex_rs1_val, 32'h77);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    check("midrst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("midrst rs1_val", ex_rs1_val, 32'd0);
    check("midrst rd_wr", {26'd0, ex_rd, ex_wr_en}, 32'd0);
    check("midrst fwd", {28'd0, fwd_now()}, 32'd0);
`ifdef STALL_CNT_EN
    check("midrst stall_cnt", perf_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    id_valid = 1'b0;
    #1;
    check("post-rst id_ready", {31'd0, id_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
